store_commit_queue: RTL

Queue of committed stores in front of the single-port data memory. Accepts stores from the commit stage and drains them oldest-first into the memory's single read/write port whenever no load holds the port. Loads take priority for the port; each load is checked against the pending stores and gets its data from the youngest matching store or from memory. Sits between commit/load-issue logic and the 128-word data memory (synchronous read, one-cycle latency, addressed by `addr[6:0]`).

---
 rtl/store_commit_queue.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/store_commit_queue.sv
// store_commit_queue: committed-store queue in front of a single-port data memory.
// Stores are queued in a circular buffer and drained oldest-first whenever no
// load holds the memory port. Loads have priority, except when the queue is
// full, when the drain is given the port so that stores cannot starve.
//
// Build option:
//   STQ_FORWARD_EN defined   - an accepted load takes its data from the youngest
//                              matching queued store (or a same-cycle push).
//   STQ_FORWARD_EN undefined - a load that matches any queued store (or a
//                              same-cycle push) is stalled while the queue
//                              drains. It retries until no entry matches, and
//                              its data always comes from memory.
module store_commit_queue #(
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2,
  parameter int ADDR_LEN  = 7,
  parameter int DATA_LEN  = 32
) (
  input  logic                clk,
  input  logic                reset,
  // commit-side store push
  input  logic                st_push,
  input  logic [ADDR_LEN-1:0] st_addr,
  input  logic [DATA_LEN-1:0] st_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG:0]  count,
  // load issue
  input  logic                ld_req,
  input  logic [ADDR_LEN-1:0] ld_addr,
  output logic                ld_stall,
  output logic                ld_valid,
  output logic [DATA_LEN-1:0] ld_data,
  // single read/write memory port
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  // Owner of the memory port in the current cycle.
  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_LOAD,
    PORT_DRAIN
  } port_e;

  localparam logic [DEPTH_LOG:0] COUNT_FULL = (DEPTH_LOG + 1)'(DEPTH);

  // Queue state
  logic [DEPTH_LOG-1:0] head_q;
  logic [DEPTH_LOG-1:0] tail_q;
  logic [DEPTH_LOG:0]   count_q;
  logic [DEPTH_LOG:0]   count_next;
  logic                 full_q;
  logic                 empty_q;
  logic [DEPTH-1:0]     valid_q;
  logic [ADDR_LEN-1:0]  addr_q [DEPTH];
  logic [DATA_LEN-1:0]  data_q [DEPTH];

  // Load result pipeline
  logic                 ld_valid_q;

  // Per-cycle decisions
  port_e                grant;
  logic                 push_ok;
  logic                 drain;
  logic                 load_go;
  logic                 match_any;
  logic                 block_hit;

`ifdef STQ_FORWARD_EN
  logic [DATA_LEN-1:0]  match_data;
  logic                 fwd_hit_q;
  logic [DATA_LEN-1:0]  fwd_data_q;
`endif

  // A push is taken only when there is room; a push while full is dropped even
  // if the same cycle drains, so the producer sees a simple "never push while
  // full" rule.
  assign push_ok = st_push && !full_q && !reset;
  assign drain   = (grant == PORT_DRAIN);
  assign load_go = (grant == PORT_LOAD);

  // Address match of the load against every valid entry, walked from the head
  // so the last hit is the youngest; a same-cycle push is younger than all.
  always_comb begin
    // NOTE: every variable of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    match_any = 1'b0;
`ifdef STQ_FORWARD_EN
    match_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[head_q + DEPTH_LOG'(k)] &&
          (addr_q[head_q + DEPTH_LOG'(k)] == ld_addr)) begin
        match_any = 1'b1;
`ifdef STQ_FORWARD_EN
        match_data = data_q[head_q + DEPTH_LOG'(k)];
`endif
      end
    end
    if (push_ok && (st_addr == ld_addr)) begin
      match_any = 1'b1;
`ifdef STQ_FORWARD_EN
      match_data = st_data;
`endif
    end
  end

  // Without forwarding, a load hitting a queued store must wait for it to drain.
`ifdef STQ_FORWARD_EN
  assign block_hit = 1'b0;
`else
  assign block_hit = match_any;
`endif

  // Port arbitration: loads first, drain when full or when the load is blocked.
  always_comb begin
    grant    = PORT_IDLE;
    ld_stall = 1'b0;
    if (!reset) begin
      if (ld_req && (full_q || block_hit)) begin
        ld_stall = 1'b1;
        if (!empty_q) begin
          grant = PORT_DRAIN;
        end
      end else if (ld_req) begin
        grant = PORT_LOAD;
      end else if (!empty_q) begin
        grant = PORT_DRAIN;
      end
    end
  end

  // Memory port drive; everything reads as zero when the port is idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      PORT_LOAD: begin
        mem_addr = ld_addr;
      end
      PORT_DRAIN: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = data_q[head_q];
      end
      default: begin
      end
    endcase
  end

  // Occupancy after this edge.
  always_comb begin
    count_next = count_q;
    case ({push_ok, drain})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Pointers, valid bits, flags and the load result pipeline.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      valid_q    <= '0;
      ld_valid_q <= 1'b0;
`ifdef STQ_FORWARD_EN
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
`endif
    end else begin
      // Drain and push never touch the same slot: both at once means the queue
      // is neither empty nor full, so head and tail differ.
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push_ok) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      count_q    <= count_next;
      full_q     <= (count_next == COUNT_FULL);
      empty_q    <= (count_next == '0);
      ld_valid_q <= load_go;
`ifdef STQ_FORWARD_EN
      fwd_hit_q  <= load_go && match_any;
      fwd_data_q <= match_data;
`endif
    end
  end

  // Entry payload storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; the valid bits alone decide whether
    // an entry means anything, so clearing the data would only cost logic.
    if (push_ok) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign ld_valid = ld_valid_q;

  // The memory answers one cycle after the load was accepted, which lines up
  // with the registered forwarding decision.
`ifdef STQ_FORWARD_EN
  assign ld_data = ld_valid_q ? (fwd_hit_q ? fwd_data_q : mem_rdata) : '0;
`else
  assign ld_data = ld_valid_q ? mem_rdata : '0;
`endif

endmodule
